// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: pipeline stage register with valid/ready handshake and a
// 2-entry skid buffer (main + skid). in_ready is registered so there is no
// combinational ready path between neighbouring stages. Control bits are
// zeroed on bubbles and flushes, so an invalid entry always behaves as a NOP.
// Optional statistics counters are built when PIPE_STAT_EN is defined.
module pipe_stage_skid #(
   parameter int DATA_W = 32,
   parameter int CTRL_W = 16
`ifdef PIPE_STAT_EN
   ,
   parameter int STAT_W = 16
`endif
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl
`ifdef PIPE_STAT_EN
   ,
   output logic [STAT_W-1:0] stall_cnt,
   output logic [STAT_W-1:0] flush_cnt
`endif
);

   typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

   state_t              state_q, state_d;
   logic                in_ready_q, in_ready_d;
   logic [DATA_W-1:0]   main_data_q, main_data_d;
   logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d;
   logic [DATA_W-1:0]   skid_data_q, skid_data_d;
   logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;
   logic                acc, emit;

   assign out_valid = (state_q != EMPTY);
   assign in_ready  = in_ready_q;
   assign out_data  = main_data_q;
   // Gate by the valid bit so a stale control word can never leak out.
   assign out_ctrl  = out_valid ? main_ctrl_q : '0;

   assign acc  = in_valid & in_ready_q;
   assign emit = out_valid & out_ready;

   // Next-state and entry movement; flush overrides everything else.
   always_comb begin
      state_d     = state_q;
      main_data_d = main_data_q;
      main_ctrl_d = main_ctrl_q;
      skid_data_d = skid_data_q;
      skid_ctrl_d = skid_ctrl_q;
      if (flush) begin
         // Payload is left alone; only validity and control are killed.
         state_d     = EMPTY;
         main_ctrl_d = '0;
         skid_ctrl_d = '0;
      end else begin
         unique case (state_q)
            EMPTY: begin
               if (acc) begin
                  state_d     = ONE;
                  main_data_d = in_data;
                  main_ctrl_d = in_ctrl;
               end
            end
            ONE: begin
               if (acc && emit) begin
                  main_data_d = in_data;
                  main_ctrl_d = in_ctrl;
               end else if (acc) begin
                  state_d     = FULL;
                  skid_data_d = in_data;
                  skid_ctrl_d = in_ctrl;
               end else if (emit) begin
                  state_d     = EMPTY;
                  main_ctrl_d = '0;
               end
            end
            FULL: begin
               // in_ready_q is low here, so no new entry can arrive.
               if (emit) begin
                  state_d     = ONE;
                  main_data_d = skid_data_q;
                  main_ctrl_d = skid_ctrl_q;
                  skid_ctrl_d = '0;
               end
            end
            default: begin
               state_d     = EMPTY;
               main_ctrl_d = '0;
               skid_ctrl_d = '0;
            end
         endcase
      end
      in_ready_d = (state_d != FULL);
   end

   // State, ready and entry registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= EMPTY;
         in_ready_q  <= 1'b1;
         main_data_q <= '0;
         main_ctrl_q <= '0;
         skid_data_q <= '0;
         skid_ctrl_q <= '0;
      end else begin
         state_q     <= state_d;
         in_ready_q  <= in_ready_d;
         main_data_q <= main_data_d;
         main_ctrl_q <= main_ctrl_d;
         skid_data_q <= skid_data_d;
         skid_ctrl_q <= skid_ctrl_d;
      end
   end

`ifdef PIPE_STAT_EN
   logic [STAT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [STAT_W-1:0] flush_cnt_q, flush_cnt_d;

   function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   // Saturating statistics: stalled cycles and flushes that killed something.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (out_valid && !out_ready) stall_cnt_d = sat_inc(stall_cnt_q);
      if (flush && out_valid)      flush_cnt_d = sat_inc(flush_cnt_q);
   end

   // Counter registers, cleared only by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`endif

endmodule
